uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side byte buffer directly downstream of the UART receiver.
//  - Accepts every byte the receiver produces; the receiver has no back-pressure handling.
//  - Holds up to DEPTH bytes in first-word-fall-through order for the CPU MMIO read path.
//  - Reports occupancy and a sticky overrun flag when a byte arrives while the buffer is full.
// PARAMETERS
//  DEPTH   8   number of byte entries; power of two, >= 2
//  WIDTH   8   data width in bits
// PORTS
//  clk           in   1                  single clock; all logic on posedge
//  rst_n         in   1                  asynchronous, active-low reset
//  enq_data      in   WIDTH              byte from the receiver's data_out
//  enq_valid     in   1                  receiver's data_out_valid
//  enq_ready     out  1                  to the receiver's data_out_ready; constant 1
//  deq_data      out  WIDTH              head entry; valid while deq_valid = 1
//  deq_valid     out  1                  FIFO not empty
//  deq_ready     in   1                  consumer pops the head this cycle
//  count         out  $clog2(DEPTH)+1    number of stored entries, 0..DEPTH
//  full          out  1                  count == DEPTH
//  overrun       out  1                  sticky: a byte was dropped because the FIFO was full
//  overrun_clr   in   1                  synchronous clear of overrun
// BEHAVIOUR
//  - Reset (rst_n = 0, async assert, sync deassert at the source):
//    rd_ptr = wr_ptr = 0, count = 0, overrun = 0, deq_valid = 0, full = 0.
//    deq_data is don't-care. Reset mid-transfer discards all contents.
//  - Storage: DEPTH x WIDTH register array.
//    Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//    count is a separate counter (no pointer-MSB trick required).
//  - Handshakes:
//    push = enq_valid & enq_ready; enq_ready is tied to 1, so every receiver byte is consumed in one cycle.
//    pop  = deq_valid & deq_ready.
//  - Write: push & (~full | pop)
//    -> mem[wr_ptr] <= enq_data; wr_ptr++.
//  - Drop: push & full & ~pop
//    -> byte discarded, overrun <= 1; pointers and count unchanged.
//  - Read: pop -> rd_ptr++. deq_data = mem[rd_ptr], combinational from registers (FWFT).
//  - count update: +1 on write without pop, -1 on pop without write, unchanged when both or neither.
//  - deq_valid = (count != 0); full = (count == DEPTH). Both are derived from the registered count.
//  - Latency: a byte written at edge N is visible on deq_data/deq_valid after edge N.
//    There is no same-cycle bypass when empty.
//  - pop while empty: impossible, since deq_valid = 0; deq_ready is ignored.
//  - Simultaneous push and pop when full: the write succeeds into the freed slot, count stays DEPTH, no overrun.
//  - Simultaneous push and pop when count = 1: the head is popped and the new byte written; count stays 1.
//  - overrun:
//    set has priority over overrun_clr in the same cycle;
//    otherwise overrun_clr -> 0;
//    otherwise hold.
// TESTING
//  1. Reset with enq_valid = 0: count = 0, deq_valid = 0, full = 0, overrun = 0, enq_ready = 1.
//  2. Push 0x41, 0x42, 0x43 with deq_ready = 0, then pop 3 times:
//     deq_data reads 0x41, 0x42, 0x43; count goes 3 -> 0; deq_valid = 0 after.
//  3. Push 8 bytes 0x00..0x07 (DEPTH = 8): full = 1, count = 8.
//     Push 0xFF -> overrun = 1, count = 8, head still 0x00.
//     Assert overrun_clr -> overrun = 0.
//  4. When full, push 0x55 and pop in the same cycle:
//     0x00 leaves, count stays 8, overrun stays 0; the 8th pop returns 0x55.
//  5. Wrap-around: 20 interleaved push/pop of an incrementing pattern with count kept between 1 and 3
//     -> output sequence equals input sequence; pointers wrap with no loss.
//  6. Assert rst_n low asynchronously mid-stream with count = 5
//     -> count = 0, deq_valid = 0, overrun = 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer between the UART receiver and the CPU read path.
// The receiver cannot stall, so bytes arriving while full are dropped and flagged as overrun.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         enq_data,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  output logic [WIDTH-1:0]         deq_data,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overrun,
  input  logic                     overrun_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overrun;

  logic w_push;
  logic w_pop;
  logic w_write;
  logic w_drop;
  logic w_full;
  logic w_not_empty;

  assign w_not_empty = (r_count != '0);
  assign w_full      = (r_count == CW'(DEPTH));

  assign w_push  = enq_valid & enq_ready;
  assign w_pop   = w_not_empty & deq_ready;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign w_write = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= enq_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_write && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_write) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign enq_ready = 1'b1;
  assign deq_data  = r_mem[r_rd_ptr];
  assign deq_valid = w_not_empty;
  assign count     = r_count;
  assign full      = w_full;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue scoreboard models the stored bytes,
// occupancy and the sticky overrun flag.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] enq_data;
  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] deq_data;
  logic             deq_valid;
  logic             deq_ready;
  logic [3:0]       count;
  logic             full;
  logic             overrun;
  logic             overrun_clr;

  logic [WIDTH-1:0] exp_q[$];
  logic             m_ovr;
  int               total_cnt;
  int               bad_cnt;

  uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enq_data    (enq_data),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .deq_data    (deq_data),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .count       (count),
    .full        (full),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare all status outputs against the scoreboard state.
  task automatic check_status(input string tag);
    check_val({tag, ".count"}, 32'(count), 32'(exp_q.size()));
    check_val({tag, ".full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    check_val({tag, ".deq_valid"}, 32'(deq_valid), 32'(exp_q.size() != 0));
    check_val({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    if (exp_q.size() != 0) begin
      check_val({tag, ".head"}, 32'(deq_data), 32'(exp_q[0]));
    end
  endtask

  // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cyc(input string tag, input bit push, input logic [7:0] d,
                     input bit pop, input bit clr);
    bit was_full;
    bit pop_eff;
    bit drop;
    enq_valid   = push;
    enq_data    = d;
    deq_ready   = pop;
    overrun_clr = clr;
    was_full = (exp_q.size() == DEPTH);
    pop_eff  = pop && (exp_q.size() != 0);
    drop     = push && was_full && !pop_eff;
    if (pop_eff) begin
      check_val({tag, ".pop_data"}, 32'(deq_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (push && !drop) exp_q.push_back(d);
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    @(posedge clk);
    #1;
    enq_valid   = 1'b0;
    deq_ready   = 1'b0;
    overrun_clr = 1'b0;
    $display("cycle %-10s push=%0d d=%02h pop=%0d clr=%0d -> count=%0d deq=%02h ovr=%0d",
             tag, push, d, pop, clr, count, deq_data, overrun);
    check_status(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] nxt;
    int pushed;
    total_cnt   = 0;
    bad_cnt     = 0;
    m_ovr       = 1'b0;
    rst_n       = 1'b0;
    enq_valid   = 1'b0;
    enq_data    = '0;
    deq_ready   = 1'b0;
    overrun_clr = 1'b0;

    // 1. reset state
    repeat (2) @(posedge clk);
    #1;
    check_status("reset");
    check_val("reset.enq_ready", 32'(enq_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_status("post_reset");

    // 2. three pushes then three pops, plus a pop attempt while empty
    cyc("t2_push", 1, 8'h41, 0, 0);
    cyc("t2_push", 1, 8'h42, 0, 0);
    cyc("t2_push", 1, 8'h43, 0, 0);
    repeat (3) cyc("t2_pop", 0, 8'h00, 1, 0);
    cyc("t2_popmt", 0, 8'h00, 1, 0);

    // 3. fill, overflow, clear
    for (int i = 0; i < DEPTH; i++) cyc("t3_fill", 1, 8'(i), 0, 0);
    cyc("t3_ovf", 1, 8'hFF, 0, 0);
    cyc("t3_idle", 0, 8'h00, 0, 0);
    cyc("t3_clr", 0, 8'h00, 0, 1);

    // 4. push and pop together while full
    cyc("t4_both", 1, 8'h55, 1, 0);
    for (int i = 0; i < DEPTH; i++) cyc("t4_drain", 0, 8'h00, 1, 0);

    // 5. interleaved traffic with occupancy held in 1..3 so both pointers wrap
    nxt = 8'h80;
    pushed = 0;
    cyc("t5_prime", 1, nxt, 0, 0);
    nxt++;
    pushed++;
    for (int i = 0; pushed < 20 && i < 200; i++) begin
      if (exp_q.size() <= 1) begin
        cyc("t5_push", 1, nxt, 0, 0);
        nxt++;
        pushed++;
      end else if (exp_q.size() >= 3) begin
        cyc("t5_pop", 0, 8'h00, 1, 0);
      end else if (i % 3 == 0) begin
        cyc("t5_pop", 0, 8'h00, 1, 0);
      end else begin
        cyc("t5_both", 1, nxt, 1, 0);
        nxt++;
        pushed++;
      end
      check_val("t5.range", 32'(count >= 4'd1 && count <= 4'd3), 32'd1);
    end
    while (exp_q.size() != 0) cyc("t5_drain", 0, 8'h00, 1, 0);

    // 6. async reset with count=5 and overrun set
    for (int i = 0; i < DEPTH; i++) cyc("t6_fill", 1, 8'(8'hA0 + i), 0, 0);
    cyc("t6_ovf", 1, 8'hEE, 0, 0);
    repeat (3) cyc("t6_pop", 0, 8'h00, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_ovr = 1'b0;
    $display("async reset asserted mid-cycle -> count=%0d deq_valid=%0d ovr=%0d",
             count, deq_valid, overrun);
    check_val("t6_rst.count", 32'(count), 32'd0);
    check_val("t6_rst.deq_valid", 32'(deq_valid), 32'd0);
    check_val("t6_rst.overrun", 32'(overrun), 32'd0);
    check_val("t6_rst.full", 32'(full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("t6_after", 1, 8'h5A, 0, 0);
    cyc("t6_after", 0, 8'h00, 1, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
